seg_entry_controller: RTL

- Produces the character-buffer and mode inputs consumed by the 4-digit seven-segment display driver: `characters`, `seg`, `loadedChar` and `State`.
- Lets the user compose a glyph on eight slide switches, latch it, and commit it into a scrolling 4-character buffer.
- Buttons are synchronised, debounced and edge-detected here.
- A mode FSM drives the display's "L" (edit) and "o" (loaded) screens.

---
 rtl/seg_entry_controller.sv | 111 +++++++++++
 1 files changed

// File: rtl/seg_entry_controller.sv
// seg_entry_controller: switch glyph entry, button conditioning and mode FSM feeding the 4-digit display
module seg_entry_button #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clock_100Mhz,
   input  logic reset,
   input  logic raw,
   output logic pulse
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
   logic [1:0] sync;
   logic level, level_d;
   logic [CW-1:0] cnt;
   always_ff @(posedge clock_100Mhz or posedge reset)
      if (reset) begin
         sync <= '0;
         level <= 1'b0;
         level_d <= 1'b0;
         cnt <= '0;
         pulse <= 1'b0;
      end else begin
         sync <= {sync[0], raw};
         level_d <= level;
         pulse <= level & ~level_d;
         cnt <= (sync[1] == level || cnt == CNT_MAX) ? '0 : cnt + 1'b1;
         if (sync[1] != level && cnt == CNT_MAX) level <= ~level;
      end
endmodule

module seg_entry_controller #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int HOLD_CYCLES = 200_000_000
) (
   input  logic        clock_100Mhz,
   input  logic        reset,
   input  logic [7:0]  sw,
   input  logic        btn_edit,
   input  logic        btn_load,
   input  logic        btn_commit,
   input  logic        btn_clear,
   output logic [31:0] characters,
   output logic [7:0]  seg,
   output logic [7:0]  loadedChar,
   output logic [2:0]  State
);
   typedef enum logic [2:0] {SHOW = 3'b000, EDIT = 3'b110, LOADED = 3'b111} mode_t;
   localparam int HW = $clog2(HOLD_CYCLES);
   localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES - 1);
   mode_t mode;
   logic [HW-1:0] hold;
   logic [7:0] sw_meta, sw_sync;
   logic edit_p, load_p, commit_p, clear_p;
   seg_entry_button #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_edit (
      .clock_100Mhz(clock_100Mhz), .reset(reset), .raw(btn_edit), .pulse(edit_p));
   seg_entry_button #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (
      .clock_100Mhz(clock_100Mhz), .reset(reset), .raw(btn_load), .pulse(load_p));
   seg_entry_button #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_commit (
      .clock_100Mhz(clock_100Mhz), .reset(reset), .raw(btn_commit), .pulse(commit_p));
   seg_entry_button #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
      .clock_100Mhz(clock_100Mhz), .reset(reset), .raw(btn_clear), .pulse(clear_p));
   assign State = mode;
   always_ff @(posedge clock_100Mhz or posedge reset)
      if (reset) begin
         sw_meta <= '0;
         sw_sync <= '0;
         seg <= 8'hFF;
      end else begin
         sw_meta <= sw;
         sw_sync <= sw_meta;
         seg <= ~sw_sync;
      end
   // pulse priority: clear > edit > commit > load
   always_ff @(posedge clock_100Mhz or posedge reset)
      if (reset) begin
         mode <= SHOW;
         characters <= 32'hFFFF_FFFF;
         loadedChar <= 8'hFF;
         hold <= '0;
      end else if (clear_p) begin
         mode <= SHOW;
         characters <= 32'hFFFF_FFFF;
         loadedChar <= 8'hFF;
         hold <= '0;
      end else if (edit_p) begin
         mode <= (mode == SHOW) ? EDIT : SHOW;
      end else begin
         case (mode)
            EDIT:
               if (load_p) begin
                  loadedChar <= seg;
                  hold <= '0;
                  mode <= LOADED;
               end
            LOADED:
               if (commit_p) begin
                  characters <= {characters[23:0], loadedChar};
                  mode <= SHOW;
               end else if (load_p) begin
                  loadedChar <= seg;
                  hold <= '0;
               end else if (hold == HOLD_MAX) begin
                  hold <= '0;
                  mode <= EDIT;
               end else begin
                  hold <= hold + 1'b1;
               end
            default: ;
         endcase
      end
endmodule
